// File: rtl/accelerator_read_strength.sv
// rtl/accelerator_read_strength.sv - per-head read strength beta_r = oneplus(beta^_r), one element at a time
// Optional saturation of ONE + softplus: define ACCELERATOR_READ_STRENGTH_SATURATION_EN.
// Without it the sum wraps modulo 2^DATA_SIZE and no overflow logic exists.
// Sequence per element: INPUT (wait for BETA_IN_ENABLE) -> COMPUTE -> OUTPUT.
module accelerator_read_strength #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_R_IN,
  input  logic                    BETA_IN_ENABLE,
  output logic                    BETA_ENABLE,
  input  logic [DATA_SIZE-1:0]    BETA_IN,
  output logic                    BETA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    BETA_OUT
);

  localparam int FRAC = DATA_SIZE / 2;

  // Fixed-point constants: 1.0 and 4.0 in Q(DATA_SIZE-FRAC).FRAC
  localparam logic signed [DATA_SIZE-1:0] ONE      = DATA_SIZE'(1) << FRAC;
  localparam logic signed [DATA_SIZE-1:0] FOUR     = DATA_SIZE'(4) << FRAC;
  localparam logic signed [DATA_SIZE-1:0] NEG_FOUR = -FOUR;

`ifdef ACCELERATOR_READ_STRENGTH_SATURATION_EN
  localparam logic [DATA_SIZE-1:0] MAX_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_INPUT   = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  logic [1:0]              state_q,    state_d;
  logic [CONTROL_SIZE-1:0] size_q,     size_d;
  logic [CONTROL_SIZE-1:0] index_q,    index_d;
  logic [DATA_SIZE-1:0]    beta_in_q,  beta_in_d;
  logic [DATA_SIZE-1:0]    beta_out_q, beta_out_d;
  logic                    out_en_q,   out_en_d;
  logic                    ready_q,    ready_d;

  logic                    last_elem;

  logic signed [DATA_SIZE-1:0]   x_s;
  logic signed [DATA_SIZE-1:0]   shifted;
  logic signed [2*DATA_SIZE-1:0] shifted_w;
  logic signed [2*DATA_SIZE-1:0] square;
  logic [DATA_SIZE-1:0]          softplus_mid;
  logic [DATA_SIZE-1:0]          softplus;
  logic [DATA_SIZE-1:0]          sum;
  logic [DATA_SIZE-1:0]          oneplus_res;

  // oneplus datapath: softplus approximated by (x+4)^2/16 inside (-4,4), clamped outside
  always_comb begin
    x_s          = $signed(beta_in_q);
    shifted      = x_s + FOUR;
    shifted_w    = (2*DATA_SIZE)'(shifted);
    square       = shifted_w * shifted_w;
    softplus_mid = DATA_SIZE'(square >>> (FRAC + 4));
    if (x_s <= NEG_FOUR) begin
      softplus = '0;
    end else if (x_s >= FOUR) begin
      softplus = beta_in_q;
    end else begin
      softplus = softplus_mid;
    end
    // softplus is never negative, so an overflow of the sum shows up as the sign bit
    sum = ONE + softplus;
`ifdef ACCELERATOR_READ_STRENGTH_SATURATION_EN
    oneplus_res = sum[DATA_SIZE-1] ? MAX_POS : sum;
`else
    oneplus_res = sum;
`endif
  end

  assign last_elem = ((index_q + CONTROL_SIZE'(1)) == size_q);

  // Element sequencer: accept one element, compute it, emit it, repeat R times
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    index_d    = index_q;
    beta_in_d  = beta_in_q;
    beta_out_d = beta_out_q;
    out_en_d   = 1'b0;
    ready_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          size_d  = SIZE_R_IN;
          index_d = '0;
          if (SIZE_R_IN == '0) begin
            // nothing to process: report completion straight away
            ready_d = 1'b1;
          end else begin
            state_d = S_INPUT;
          end
        end
      end
      S_INPUT: begin
        if (BETA_IN_ENABLE) begin
          beta_in_d = BETA_IN;
          state_d   = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        // result and strobes are registered here so they are visible during OUTPUT
        beta_out_d = oneplus_res;
        out_en_d   = 1'b1;
        ready_d    = last_elem;
        state_d    = S_OUTPUT;
      end
      S_OUTPUT: begin
        index_d = index_q + CONTROL_SIZE'(1);
        state_d = last_elem ? S_IDLE : S_INPUT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      index_q    <= '0;
      beta_in_q  <= '0;
      beta_out_q <= '0;
      out_en_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      index_q    <= index_d;
      beta_in_q  <= beta_in_d;
      beta_out_q <= beta_out_d;
      out_en_q   <= out_en_d;
      ready_q    <= ready_d;
    end
  end

  assign BETA_ENABLE     = (state_q == S_INPUT);
  assign BETA_OUT_ENABLE = out_en_q;
  assign BETA_OUT        = beta_out_q;
  assign READY           = ready_q;

endmodule

// File: tb/tb_accelerator_read_strength.sv
// tb/tb_accelerator_read_strength.sv - directed self-checking bench for accelerator_read_strength
module tb_accelerator_read_strength;

  localparam int DW = 32;
  localparam int CW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          READY;
  logic [CW-1:0] SIZE_R_IN = '0;
  logic          BETA_IN_ENABLE = 1'b0;
  logic          BETA_ENABLE;
  logic [DW-1:0] BETA_IN = '0;
  logic          BETA_OUT_ENABLE;
  logic [DW-1:0] BETA_OUT;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] out_q[$];
  int            outc_q[$];
  int            acc_q[$];
  int            rdy_q[$];
  int            en_cnt = 0;

  accelerator_read_strength #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .READY(READY),
    .SIZE_R_IN(SIZE_R_IN),
    .BETA_IN_ENABLE(BETA_IN_ENABLE),
    .BETA_ENABLE(BETA_ENABLE),
    .BETA_IN(BETA_IN),
    .BETA_OUT_ENABLE(BETA_OUT_ENABLE),
    .BETA_OUT(BETA_OUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (BETA_IN_ENABLE === 1'b1 && BETA_ENABLE === 1'b1) acc_q.push_back(cyc);
    if (BETA_OUT_ENABLE === 1'b1) begin
      out_q.push_back(BETA_OUT);
      outc_q.push_back(cyc);
    end
    if (READY === 1'b1) rdy_q.push_back(cyc);
    if (BETA_ENABLE === 1'b1) en_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_mon();
    out_q.delete();
    outc_q.delete();
    acc_q.delete();
    rdy_q.delete();
    en_cnt = 0;
  endtask

  task automatic do_start(input int r);
    SIZE_R_IN = CW'(r);
    START = 1'b1;
    tick(1);
    START = 1'b0;
  endtask

  task automatic send_elem(input logic [DW-1:0] d);
    int w;
    w = 0;
    while (BETA_ENABLE !== 1'b1 && w < 50) begin
      tick(1);
      w++;
    end
    n_checks++;
    if (w >= 50) begin
      n_fail++;
      $display("FAIL send_timeout: BETA_ENABLE=%b after %0d cycles, required 1", BETA_ENABLE, w);
    end else begin
      BETA_IN = d;
      BETA_IN_ENABLE = 1'b1;
      tick(1);
      BETA_IN_ENABLE = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(3);
    n_checks++;
    if (READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", READY); end
    n_checks++;
    if (BETA_ENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_beta_enable: got %b want 0", BETA_ENABLE); end
    n_checks++;
    if (BETA_OUT_ENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_out_enable: got %b want 0", BETA_OUT_ENABLE); end
    n_checks++;
    if (BETA_OUT !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_beta_out: got %h want 00000000", BETA_OUT); end
    RST = 1'b1;
    tick(2);
    n_checks++;
    if (BETA_ENABLE !== 1'b0 || READY !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: beta_enable=%b ready=%b want 0 0", BETA_ENABLE, READY);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] vin [4];
    logic [DW-1:0] vexp[4];
    vin  = '{32'h0000_0000, 32'hFFFC_0000, 32'h0005_0000, 32'h0002_0000};
    vexp = '{32'h0002_0000, 32'h0001_0000, 32'h0006_0000, 32'h0003_4000};
    clear_mon();
    do_start(4);
    for (int i = 0; i < 4; i++) send_elem(vin[i]);
    tick(4);
    n_checks++;
    if (out_q.size() != 4) begin n_fail++; $display("FAIL stream_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < out_q.size()) begin
        n_checks++;
        if (out_q[i] !== vexp[i]) begin n_fail++; $display("FAIL stream_value[%0d]: got %h want %h", i, out_q[i], vexp[i]); end
      end
      if (i < outc_q.size() && i < acc_q.size()) begin
        n_checks++;
        if (outc_q[i] - acc_q[i] != 2) begin n_fail++; $display("FAIL stream_latency[%0d]: got %0d want 2", i, outc_q[i] - acc_q[i]); end
      end
    end
    if (acc_q.size() >= 2) begin
      n_checks++;
      if (acc_q[1] - acc_q[0] != 3) begin n_fail++; $display("FAIL back_to_back_period: got %0d want 3", acc_q[1] - acc_q[0]); end
    end
    n_checks++;
    if (rdy_q.size() != 1) begin
      n_fail++;
      $display("FAIL stream_ready_count: got %0d want 1", rdy_q.size());
    end else if (outc_q.size() == 4) begin
      n_checks++;
      if (rdy_q[0] != outc_q[3]) begin n_fail++; $display("FAIL stream_ready_cycle: got %0d want %0d", rdy_q[0], outc_q[3]); end
    end
  endtask

  task automatic test_gaps();
    int gaps[3];
    logic [DW-1:0] vin [3];
    logic [DW-1:0] vexp[3];
    int w;
    gaps = '{0, 5, 1};
    vin  = '{32'hFFFE_0000, 32'h0000_8000, 32'h0003_FFFF};
    vexp = '{32'h0001_4000, 32'h0002_4400, 32'h0004_FFFF};
    clear_mon();
    do_start(3);
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (BETA_ENABLE !== 1'b1 && w < 20) begin tick(1); w++; end
      n_checks++;
      if (w >= 20) begin n_fail++; $display("FAIL gaps_enable_timeout[%0d]: got %b want 1", k, BETA_ENABLE); end
      for (int j = 0; j < gaps[k]; j++) begin
        n_checks++;
        if (BETA_ENABLE !== 1'b1) begin n_fail++; $display("FAIL gaps_enable_hold[%0d.%0d]: got %b want 1", k, j, BETA_ENABLE); end
        if (k == 1 && j == 2) begin
          SIZE_R_IN = 32'd1;
          START = 1'b1;
        end
        tick(1);
        START = 1'b0;
      end
      BETA_IN = vin[k];
      BETA_IN_ENABLE = 1'b1;
      tick(1);
      BETA_IN_ENABLE = 1'b0;
    end
    tick(5);
    n_checks++;
    if (out_q.size() != 3) begin n_fail++; $display("FAIL gaps_count: got %0d want 3", out_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < out_q.size()) begin
        n_checks++;
        if (out_q[i] !== vexp[i]) begin n_fail++; $display("FAIL gaps_value[%0d]: got %h want %h", i, out_q[i], vexp[i]); end
      end
    end
    n_checks++;
    if (rdy_q.size() != 1) begin n_fail++; $display("FAIL gaps_ready_count: got %0d want 1", rdy_q.size()); end
    n_checks++;
    if (BETA_ENABLE !== 1'b0) begin n_fail++; $display("FAIL gaps_idle_after: beta_enable=%b want 0", BETA_ENABLE); end
  endtask

  task automatic test_size_zero();
    int sc;
    clear_mon();
    SIZE_R_IN = '0;
    START = 1'b1;
    sc = cyc;
    tick(1);
    START = 1'b0;
    BETA_IN = 32'h0001_0000;
    BETA_IN_ENABLE = 1'b1;
    tick(2);
    BETA_IN_ENABLE = 1'b0;
    tick(4);
    n_checks++;
    if (rdy_q.size() != 1) begin
      n_fail++;
      $display("FAIL zero_ready_count: got %0d want 1", rdy_q.size());
    end else begin
      n_checks++;
      if (rdy_q[0] != sc + 1) begin n_fail++; $display("FAIL zero_ready_cycle: got %0d want %0d", rdy_q[0], sc + 1); end
    end
    n_checks++;
    if (en_cnt != 0) begin n_fail++; $display("FAIL zero_beta_enable: high for %0d cycles want 0", en_cnt); end
    n_checks++;
    if (out_q.size() != 0) begin n_fail++; $display("FAIL idle_input_ignored: got %0d outputs want 0", out_q.size()); end
  endtask

  task automatic test_single();
    clear_mon();
    do_start(1);
    send_elem(32'h0004_0000);
    tick(4);
    n_checks++;
    if (out_q.size() != 1 || rdy_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_counts: outputs %0d ready %0d want 1 1", out_q.size(), rdy_q.size());
    end else begin
      n_checks++;
      if (out_q[0] !== 32'h0005_0000) begin n_fail++; $display("FAIL single_value: got %h want 00050000", out_q[0]); end
      n_checks++;
      if (rdy_q[0] != outc_q[0]) begin n_fail++; $display("FAIL single_ready_cycle: got %0d want %0d", rdy_q[0], outc_q[0]); end
    end
  endtask

  task automatic test_boundary_values();
    logic [DW-1:0] vin [3];
    logic [DW-1:0] vexp[3];
    vin  = '{32'hFFFC_0001, 32'hFFF8_0000, 32'h0003_FFFF};
    vexp = '{32'h0001_0000, 32'h0001_0000, 32'h0004_FFFF};
    clear_mon();
    do_start(3);
    for (int i = 0; i < 3; i++) send_elem(vin[i]);
    tick(4);
    n_checks++;
    if (out_q.size() != 3) begin n_fail++; $display("FAIL bound_count: got %0d want 3", out_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < out_q.size()) begin
        n_checks++;
        if (out_q[i] !== vexp[i]) begin n_fail++; $display("FAIL bound_value[%0d]: got %h want %h", i, out_q[i], vexp[i]); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] want;
`ifdef ACCELERATOR_READ_STRENGTH_SATURATION_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h8000_0000;
`endif
    clear_mon();
    do_start(1);
    send_elem(32'h7FFF_0000);
    tick(4);
    n_checks++;
    if (out_q.size() != 1) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d want 1", out_q.size());
    end else begin
      n_checks++;
      if (out_q[0] !== want) begin n_fail++; $display("FAIL overflow_value: got %h want %h", out_q[0], want); end
    end
  endtask

  task automatic test_reset_abort();
    clear_mon();
    do_start(4);
    send_elem(32'h0000_0000);
    send_elem(32'h0005_0000);
    tick(2);
    n_checks++;
    if (out_q.size() != 2) begin n_fail++; $display("FAIL abort_pre_count: got %0d want 2", out_q.size()); end
    clear_mon();
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
    BETA_IN = 32'h0002_0000;
    BETA_IN_ENABLE = 1'b1;
    tick(2);
    BETA_IN_ENABLE = 1'b0;
    tick(4);
    n_checks++;
    if (out_q.size() != 0 || rdy_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_no_output: outputs %0d ready %0d want 0 0", out_q.size(), rdy_q.size());
    end
    n_checks++;
    if (BETA_OUT !== 32'h0 || BETA_ENABLE !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: beta_out=%h beta_enable=%b want 00000000 0", BETA_OUT, BETA_ENABLE);
    end
    clear_mon();
    do_start(2);
    send_elem(32'h0000_0000);
    send_elem(32'h0005_0000);
    tick(4);
    n_checks++;
    if (out_q.size() != 2 || rdy_q.size() != 1) begin
      n_fail++;
      $display("FAIL abort_restart_counts: outputs %0d ready %0d want 2 1", out_q.size(), rdy_q.size());
    end else begin
      n_checks++;
      if (out_q[0] !== 32'h0002_0000 || out_q[1] !== 32'h0006_0000) begin
        n_fail++;
        $display("FAIL abort_restart_values: got %h %h want 00020000 00060000", out_q[0], out_q[1]);
      end
      n_checks++;
      if (rdy_q[0] != outc_q[1]) begin n_fail++; $display("FAIL abort_restart_ready: got %0d want %0d", rdy_q[0], outc_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_size_zero();
    test_single();
    test_boundary_values();
    test_saturation();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accelerator_read_strength.md
Name: accelerator_read_strength

Overview:
- Read-head counterpart of the write-strength stage: computes beta_r(t) = oneplus(beta^_r(t)) for each of R read heads.
- Input and output are element streams of length SIZE_R_IN. One element is accepted, computed and emitted at a time under FSM control.
- The oneplus datapath is built in, as a fixed-point piecewise approximation, so the element sequencer and the arithmetic are verified together.
- Sits in the DNC read_heads group. It is driven by the interface vector unpacker and feeds the read content weighting.

Parameters:
- DATA_SIZE, 64, data width; signed two's complement fixed point with FRAC = DATA_SIZE/2 fractional bits.
- CONTROL_SIZE, 64, width of the size input and of the element counter.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- RST  input  1  synchronous reset, active-low.
- START  input  1  start pulse; sampled only in IDLE.
- READY  output  1  one-cycle pulse when the last element has been emitted.
- SIZE_R_IN  input  CONTROL_SIZE  number of read heads R; latched at START.
- BETA_IN_ENABLE  input  1  BETA_IN is valid this cycle.
- BETA_ENABLE  output  1  block can accept the next element.
- BETA_IN  input  DATA_SIZE  raw strength beta^_r.
- BETA_OUT_ENABLE  output  1  one-cycle pulse; BETA_OUT is valid this cycle.
- BETA_OUT  output  DATA_SIZE  oneplus(beta^_r).

Behaviour:
- Reset (RST=0 at a clock edge): FSM goes to IDLE and the counter clears. READY=0, BETA_ENABLE=0, BETA_OUT_ENABLE=0, BETA_OUT=0.
- Reset mid-operation aborts the sequence. No READY is generated and no further outputs are emitted.
- FSM states: IDLE, INPUT, COMPUTE, OUTPUT.
- IDLE:
  - START=1 latches SIZE_R_IN, clears the index and moves to INPUT.
  - If SIZE_R_IN=0, the block instead pulses READY on the next cycle and stays in IDLE.
- INPUT:
  - BETA_ENABLE=1.
  - On BETA_IN_ENABLE=1, register BETA_IN, drop BETA_ENABLE next cycle, go to COMPUTE.
  - Without BETA_IN_ENABLE, wait indefinitely.
- COMPUTE: one cycle, evaluates the oneplus approximation into a result register, then go to OUTPUT.
- OUTPUT:
  - Drive BETA_OUT and pulse BETA_OUT_ENABLE for exactly one cycle. Increment the index.
  - If index+1 == latched R: pulse READY in the same cycle as BETA_OUT_ENABLE, then go to IDLE.
  - Otherwise go to INPUT.
- Latency: 2 cycles from BETA_IN_ENABLE to BETA_OUT_ENABLE. Minimum period per element is 3 cycles.
- BETA_OUT holds its last value until the next OUTPUT.
- Ignored inputs:
  - START outside IDLE is ignored.
  - BETA_IN_ENABLE outside INPUT is ignored; the element is dropped.
- Arithmetic (ONE = 1<<FRAC, FOUR = 4<<FRAC):
  - x <= -FOUR: softplus = 0.
  - x >= FOUR: softplus = x.
  - Otherwise: softplus = ((x+FOUR)*(x+FOUR)) >> (FRAC+4). The product is a full 2*DATA_SIZE-bit signed value; truncate toward minus infinity.
  - Result = ONE + softplus.
- Overflow of ONE + x for large x is handled per the optional feature.
- The result is never negative; the minimum is ONE.

Optional Feature:
- Macro: ACCELERATOR_READ_STRENGTH_SATURATION_EN.
- Defined: if ONE + softplus exceeds the maximum positive value, BETA_OUT = 0x7FF..F (maximum positive).
- Undefined: the sum wraps modulo 2^DATA_SIZE and no detection logic is built.

Test Plan:
- DATA_SIZE=32. Reset values: hold RST=0 for 3 cycles, then RST=1 -> READY, BETA_ENABLE and BETA_OUT_ENABLE are 0, and BETA_OUT=0x00000000.
- R=4, inputs 0x00000000, 0xFFFC0000, 0x00050000, 0x00020000 -> outputs 0x00020000, 0x00010000, 0x00060000, 0x00034000 in order. Each BETA_OUT_ENABLE arrives 2 cycles after its BETA_IN_ENABLE, and READY coincides with the 4th output.
- R=3 with BETA_IN_ENABLE gaps of 0, 5 and 1 idle cycles -> BETA_ENABLE stays high while waiting, exactly 3 outputs are produced, and READY pulses once. A second START while busy is ignored.
- Boundary cases:
  - SIZE_R_IN=0 with START -> READY pulses 1 cycle later and BETA_ENABLE never rises.
  - R=1 -> READY and BETA_OUT_ENABLE occur in the same cycle.
- Input 0x7FFF0000:
  - With ACCELERATOR_READ_STRENGTH_SATURATION_EN -> BETA_OUT = 0x7FFFFFFF.
  - Without it -> BETA_OUT = 0x80000000.
- Reset abort: with R=4, assert RST=0 after the 2nd output -> no further BETA_OUT_ENABLE or READY. A fresh START with R=2 then completes normally.
